// File: rtl/restoring_divider_recombiner_pkg.sv
// Shared widths, FSM state encoding and reference arithmetic for the restoring divider family.
// Pure declarations; no latency or backpressure of its own.
package restoring_div_pkg;

  localparam int QW = 4;
  localparam int DW = 3;
  localparam int RW = 4;
  localparam int NW = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Full-width dividend rebuilt from a divider result; unsigned throughout.
  function automatic int unsigned recomb_ref(input int unsigned q,
                                             input int unsigned div,
                                             input int unsigned rem);
    return q * div + rem;
  endfunction

endpackage

// File: rtl/restoring_divider_recombiner_if.sv
// Operand/result handshake bundle between a producer and the recombiner.
// Carries valid/ready on both sides; no storage, no latency.
interface restoring_divider_recombiner_if #(
  parameter int QW = 4,
  parameter int DW = 3,
  parameter int RW = 4,
  parameter int NW = 6
) ();

  logic          in_valid;
  logic          in_ready;
  logic [QW-1:0] q;
  logic [DW-1:0] div;
  logic [RW-1:0] rem;
  logic          out_valid;
  logic          out_ready;
  logic [NW-1:0] prod;
  logic          ovf;
  logic          rem_err;

  modport master (
    output in_valid, q, div, rem, out_ready,
    input  in_ready, out_valid, prod, ovf, rem_err
  );

  modport slave (
    input  in_valid, q, div, rem, out_ready,
    output in_ready, out_valid, prod, ovf, rem_err
  );

endinterface

// File: rtl/restoring_divider_recombiner_shift_add.sv
// One MSB-first shift-add step: acc_out = 2*acc_in + (qbit ? div : 0).
// Combinational, zero latency, no handshake.
module recomb_shift_add_step #(
  parameter int AW = 9,
  parameter int DW = 3
) (
  input  logic [AW-1:0] acc_in,
  input  logic          qbit,
  input  logic [DW-1:0] div,
  output logic [AW-1:0] acc_out
);

  assign acc_out = (acc_in << 1) + (qbit ? AW'(div) : '0);

endmodule

// File: rtl/restoring_divider_recombiner.sv
// Rebuilds dividend = q*div + rem with one shift-add per quotient bit, MSB first.
// Latency: accept on edge E, out_valid after edge E+QW+1; in_ready low until the result is taken.
module restoring_divider_recombiner
  import restoring_div_pkg::*;
#(
  parameter int QW = restoring_div_pkg::QW,
  parameter int DW = restoring_div_pkg::DW,
  parameter int RW = restoring_div_pkg::RW,
  parameter int NW = restoring_div_pkg::NW
) (
  input  logic                          clk,
  input  logic                          rst_n,
  restoring_divider_recombiner_if.slave bus
);

  localparam int AW = QW + DW + 2;
  localparam int CW = (QW > 1) ? $clog2(QW) : 1;

  state_t        state;
  logic [AW-1:0] acc;
  logic [CW-1:0] cnt;
  logic [QW-1:0] q_r;
  logic [DW-1:0] div_r;
  logic [RW-1:0] rem_r;
  logic          in_ready_r;
  logic          out_valid_r;
  logic [NW-1:0] prod_r;
  logic          ovf_r;
  logic          rem_err_r;

  logic [AW-1:0] acc_step;
  logic [AW-1:0] acc_fin;

  recomb_shift_add_step #(
    .AW (AW),
    .DW (DW)
  ) u_step (
    .acc_in  (acc),
    .qbit    (q_r[cnt]),
    .div     (div_r),
    .acc_out (acc_step)
  );

  assign acc_fin = acc + AW'(rem_r);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      acc         <= '0;
      cnt         <= '0;
      q_r         <= '0;
      div_r       <= '0;
      rem_r       <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      prod_r      <= '0;
      ovf_r       <= 1'b0;
      rem_err_r   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            q_r        <= bus.q;
            div_r      <= bus.div;
            rem_r      <= bus.rem;
            acc        <= '0;
            cnt        <= CW'(QW - 1);
            in_ready_r <= 1'b0;
            state      <= RUN;
          end
        end
        RUN: begin
          acc <= acc_step;
          cnt <= cnt - CW'(1);
          if (cnt == '0) state <= FIN;
        end
        FIN: begin
          // Result fields captured from the post-remainder sum, not the old acc.
          acc         <= acc_fin;
          prod_r      <= acc_fin[NW-1:0];
          ovf_r       <= |acc_fin[AW-1:NW];
          rem_err_r   <= (AW'(rem_r) >= AW'(div_r));
          out_valid_r <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.prod      = prod_r;
  assign bus.ovf       = ovf_r;
  assign bus.rem_err   = rem_err_r;

endmodule

// File: doc/restoring_divider_recombiner.md
Name: restoring_divider_recombiner

Overview:
Sequential inverse of the 4-bit restoring divider. Takes a quotient, divisor and remainder and rebuilds the dividend as q*div + rem, using one shift-add step per quotient bit, MSB first. The order mirrors the divider's per-stage subtract/restore. Sits beside the combinational divider as a round-trip checker and multiply path, with valid/ready handshakes on both sides.

Parameters:
QW, 4, quotient width (number of shift-add iterations)
DW, 3, divisor width
RW, 4, remainder width
NW, 6, dividend width reported on prod (matches the divider dividend input)
AW, QW+DW+2 (localparam, not overridable), internal accumulator width; no wrap for any input

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  synchronous active-low reset, sampled on clk rising edge
in_valid  in  1  operand set presented
in_ready  out  1  block can accept operands
q  in  QW  quotient
div  in  DW  divisor
rem  in  RW  remainder
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
prod  out  NW  low NW bits of q*div+rem
ovf  out  1  full result >= 2**NW
rem_err  out  1  rem >= div (includes div==0)

Behaviour:
- Reset (rst_n low at a clk edge):
  - state=IDLE; acc, cnt and operand registers cleared.
  - out_valid=0, prod=0, ovf=0, rem_err=0, in_ready=1 after that edge.
  - Reset mid-RUN/FIN/DONE aborts the operation; the partial result is discarded and never presented.
- States:
  - IDLE: in_ready=1. On in_valid, latch q/div/rem, acc=0, cnt=QW-1, then go to RUN.
  - RUN: in_ready=0. Each edge: acc=(acc<<1)+(q[cnt] ? zero-extended div : 0); cnt-=1. Edge with cnt==0 goes to FIN.
  - FIN: acc+=zero-extended rem, then go to DONE. Outputs are registered on this same edge:
    - prod=acc_new[NW-1:0]
    - ovf=|acc_new[AW-1:NW]
    - rem_err=(rem>=div), unsigned compare
  - DONE: out_valid=1; prod/ovf/rem_err held stable until out_valid&&out_ready. On that edge go to IDLE, out_valid=0. Result fields keep their last values.
- Latency: accept on edge E gives out_valid high after edge E+QW+1 (5 cycles at default).
- Throughput: one operation per QW+3 cycles minimum. in_ready is low outside IDLE, so no accept overlaps an active or pending result.
- in_valid outside IDLE is ignored; operands are not required to be stable after acceptance.
- out_ready while not DONE is ignored.
- Arithmetic is unsigned throughout. AW width guarantees no internal wrap; only prod truncates, and ovf flags it.
- rem_err and ovf are informational. The result is still produced and handshaken normally.

Decomposition:
- Shared package restoring_div_pkg:
  - width constants QW/DW/RW/NW defaults, shared with the divider.
  - state enum {IDLE, RUN, FIN, DONE}.
  - function for the reference result q*div+rem, used by the bench.
- One natural sub-module: recomb_shift_add_step (combinational, acc_in, qbit, div -> acc_out). Instantiated once and reused each RUN cycle.
- Handshake FSM and counter stay in the top.

Test Plan:
- Basic: q=10, div=5, rem=3 with out_ready=1 -> out_valid 5 cycles after accept; prod=53, ovf=0, rem_err=0.
- Overflow: q=15, div=7, rem=6 -> prod=47 (111 mod 64), ovf=1, rem_err=0.
- Invalid remainder: q=0, div=0, rem=0 -> prod=0, ovf=0, rem_err=1; q=3, div=4, rem=9 -> prod=21, rem_err=1.
- Backpressure: out_ready low 4 cycles after out_valid -> prod/ovf/rem_err/out_valid stable; in_ready stays 0; in_valid pulses ignored; release gives exactly one transfer, then in_ready=1 next cycle.
- Reset mid-operation: rst_n low during the 2nd RUN cycle -> next cycle in_ready=1, out_valid=0, prod=0. A new op q=1, div=1, rem=0 -> prod=1.
- Round trip: every rin<64, div 1..7 with rin<16*div, through the divider then this block -> prod==rin, ovf=0, rem_err=0. Back-to-back with in_valid held high.
